bram_prefix_sum_ctrl: RTL and testbench

- BRAM-port master that sits directly upstream of the behavioural BRAM model.
- On a start pulse it reads a vector of 32-bit words from a source region and computes a running (prefix) sum.
- It writes each partial sum to a destination region, then raises done; the memory model uses done to dump its contents to file.
- It is the stimulus and compute stage that drives the BRAM_* port set.

---
 rtl/bram_prefix_sum_ctrl.sv | 170 +++++++++++++++++
 tb/tb_bram_prefix_sum_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_prefix_sum_ctrl.sv
// ---------------------------------------------------------------------------
// bram_prefix_sum_ctrl
//
// BRAM-port master that reads num_words 32-bit words starting at SRC_BASE,
// forms their running sum and writes each partial sum to DST_BASE onward.
// Each word takes three cycles: read request (RD), read data return (WAIT),
// write of the updated sum (WR). done is raised when the last sum is written
// and holds until the next accepted start.
//
// Ports:
//   BRAM_CLK     in   clock, rising edge
//   BRAM_RST     in   synchronous active-high reset
//   start        in   one-cycle request, honoured only in IDLE or DONE
//   num_words    in   vector length, latched when start is accepted
//   BRAM_ADDR    out  byte address (word aligned)
//   BRAM_WRDATA  out  write data (partial sum)
//   BRAM_RDDATA  in   read data, valid the cycle after a read request
//   BRAM_EN      out  port enable
//   BRAM_WE      out  byte write enables, all-or-nothing
//   busy         out  run in progress
//   done         out  run complete
//
// Every output is a flop loaded from the next-state values, so there is no
// combinational path from any input to any output. A reset seen on the edge
// that would enter WR therefore suppresses that write entirely.
// ---------------------------------------------------------------------------
module bram_prefix_sum_ctrl #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int SRC_BASE        = 0,
  parameter int DST_BASE        = 16384
) (
  input  logic                       BRAM_CLK,
  input  logic                       BRAM_RST,
  input  logic                       start,
  input  logic [BRAM_ADDR_WIDTH-3:0] num_words,
  output logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [31:0]                BRAM_WRDATA,
  input  logic [31:0]                BRAM_RDDATA,
  output logic                       BRAM_EN,
  output logic [3:0]                 BRAM_WE,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int IW = BRAM_ADDR_WIDTH - 2;

  localparam logic [AW-1:0] SRC_A = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A = AW'(DST_BASE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q,   cnt_d;
  logic [IW-1:0]   idx_q,   idx_d;
  logic [31:0]     acc_q,   acc_d;

  logic [AW-1:0]   addr_q,   addr_d;
  logic [31:0]     wrdata_q, wrdata_d;
  logic            en_q,     en_d;
  logic [3:0]      we_q,     we_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;

  // Word index to byte offset; the sum wraps modulo 2^AW with the base.
  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base,
                                              input logic [IW-1:0] idx);
    return base + {idx, 2'b00};
  endfunction

  // Next-state and control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d   = num_words;
          idx_d   = '0;
          acc_d   = '0;
          state_d = (num_words == '0) ? S_DONE : S_RD;
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        acc_d   = acc_q + BRAM_RDDATA;
        state_d = S_WR;
      end
      S_WR: begin
        if (idx_q == cnt_q - IW'(1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Port values for the cycle being entered, decoded from the next state
  always_comb begin
    addr_d   = '0;
    wrdata_d = '0;
    en_d     = 1'b0;
    we_d     = 4'h0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_d)
      S_RD: begin
        en_d   = 1'b1;
        addr_d = word_addr(SRC_A, idx_d);
        busy_d = 1'b1;
      end
      S_WAIT: busy_d = 1'b1;
      S_WR: begin
        en_d     = 1'b1;
        we_d     = 4'hF;
        addr_d   = word_addr(DST_A, idx_d);
        wrdata_d = acc_d;
        busy_d   = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge BRAM_CLK) begin
    if (BRAM_RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      en_q     <= 1'b0;
      we_q     <= 4'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      en_q     <= en_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BRAM_ADDR   = addr_q;
  assign BRAM_WRDATA = wrdata_q;
  assign BRAM_EN     = en_q;
  assign BRAM_WE     = we_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_bram_prefix_sum_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for bram_prefix_sum_ctrl: a word-wide memory model on the BRAM
// port, table-driven prefix-sum runs, and hand-written sequences for zero
// length, start-while-busy, restart from DONE and reset mid-run. Port
// protocol is checked after every clock edge.
// ---------------------------------------------------------------------------
module tb_bram_prefix_sum_ctrl;

  localparam int AW       = 15;
  localparam int DST_WORD = 4096;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-3:0] num_words;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wrdata;
  logic [31:0]   bram_rddata;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic          busy;
  logic          done;

  // host load port into the memory model
  logic          h_we;
  logic [12:0]   h_idx;
  logic [31:0]   h_dat;

  logic [31:0]   mem [0:8191];

  int vectors    = 0;
  int miscompares = 0;
  int we_total   = 0;
  int en_total   = 0;

  always #5 clk = ~clk;

  bram_prefix_sum_ctrl #(
    .BRAM_ADDR_WIDTH(AW),
    .SRC_BASE       (0),
    .DST_BASE       (16384)
  ) dut (
    .BRAM_CLK   (clk),
    .BRAM_RST   (rst),
    .start      (start),
    .num_words  (num_words),
    .BRAM_ADDR  (bram_addr),
    .BRAM_WRDATA(bram_wrdata),
    .BRAM_RDDATA(bram_rddata),
    .BRAM_EN    (bram_en),
    .BRAM_WE    (bram_we),
    .busy       (busy),
    .done       (done)
  );

  always @(posedge clk) begin
    if (h_we) begin
      mem[h_idx] <= h_dat;
    end else if (bram_en) begin
      if (bram_we == 4'hF) mem[bram_addr[14:2]] <= bram_wrdata;
      bram_rddata <= mem[bram_addr[14:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // advance one edge, then check the port protocol on the settled outputs
  task automatic tick();
    logic ok;
    @(posedge clk);
    #1;
    ok = (bram_addr[1:0] == 2'b00) &&
         ((bram_we == 4'h0) || (bram_we == 4'hF)) &&
         ((bram_we == 4'h0) || bram_en) &&
         (!(bram_en && bram_we == 4'h0) || (bram_addr < 15'd16384)) &&
         ((bram_we == 4'h0) || (bram_addr >= 15'd16384));
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL protocol: addr=%h en=%b we=%h, required aligned/in-region/full-WE", bram_addr, bram_en, bram_we);
    end
    if (bram_we != 4'h0) we_total++;
    if (bram_en) en_total++;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    h_we  = 1'b1;
    h_idx = 13'(idx);
    h_dat = d;
    tick();
    h_we  = 1'b0;
  endtask

  // accept a start and wait for done; cyc = cycle number in which done is seen
  task automatic run(input int n, output int cyc, output logic busy1);
    num_words = (AW-2)'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    num_words = '1;       // later changes must be ignored
    cyc   = 1;
    busy1 = busy;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  typedef struct {
    int                n;
    logic [3:0][31:0]  src;
    logic [3:0][31:0]  exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int   cyc;
    logic b1;
    int   we0, en0;

    vecs[0] = '{4, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd10, 32'd6, 32'd3, 32'd1}};
    vecs[1] = '{2, {32'd0, 32'd0, 32'h2, 32'hFFFF_FFFF}, {32'd0, 32'd0, 32'h1, 32'hFFFF_FFFF}};
    vecs[2] = '{3, {32'd0, 32'd30, 32'd20, 32'd10}, {32'd0, 32'd60, 32'd30, 32'd10}};
    vecs[3] = '{1, {32'd9, 32'd9, 32'd9, 32'h8000_0000}, {32'd0, 32'd0, 32'd0, 32'h8000_0000}};
    vecs[4] = '{4, {32'hFFFF_FFFB, 32'd5, 32'h8000_0000, 32'h8000_0000},
                   {32'd0, 32'd5, 32'd0, 32'h8000_0000}};

    rst = 1'b1; start = 1'b0; num_words = '0;
    h_we = 1'b0; h_idx = '0; h_dat = '0;
    tick(); tick();
    check("reset_outputs", {15'(bram_addr), 8'(bram_wrdata), 4'(bram_we), 1'(bram_en), 1'(busy), 1'(done), 2'b00}, 32'd0);
    check("reset_wrdata", bram_wrdata, 32'd0);
    // start is overridden by reset
    start = 1'b1; num_words = 11'd3;
    tick();
    start = 1'b0;
    check("reset_over_start", {30'd0, busy, done}, 32'd0);
    rst = 1'b0;
    tick();

    // table-driven runs
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 4; k++) load(k, vecs[v].src[k]);
      for (int k = 0; k < 5; k++) load(DST_WORD + k, SENT);
      we0 = we_total; en0 = en_total;
      run(vecs[v].n, cyc, b1);
      check($sformatf("v%0d_done_cycle", v), 32'(cyc), 32'(3*vecs[v].n + 1));
      check($sformatf("v%0d_busy_first", v), {31'd0, b1}, 32'd1);
      check($sformatf("v%0d_busy_at_done", v), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_we_cycles", v), 32'(we_total - we0), 32'(vecs[v].n));
      check($sformatf("v%0d_en_cycles", v), 32'(en_total - en0), 32'(2*vecs[v].n));
      for (int k = 0; k < 5; k++) begin
        if (k < vecs[v].n) check($sformatf("v%0d_dst%0d", v, k), mem[DST_WORD + k], vecs[v].exp[k]);
        else               check($sformatf("v%0d_dst%0d_kept", v, k), mem[DST_WORD + k], SENT);
      end
      tick();
      check($sformatf("v%0d_done_held", v), {31'd0, done}, 32'd1);
    end

    // zero length
    for (int k = 0; k < 2; k++) load(DST_WORD + k, SENT);
    en0 = en_total;
    run(0, cyc, b1);
    check("zero_done_cycle", 32'(cyc), 32'd1);
    tick(); tick();
    check("zero_no_en", 32'(en_total - en0), 32'd0);
    check("zero_dst0", mem[DST_WORD], SENT);

    // start while busy is ignored; restart from DONE
    load(0, 32'd7); load(1, 32'd8); load(2, 32'd9); load(3, 32'd100);
    for (int k = 0; k < 5; k++) load(DST_WORD + k, SENT);
    num_words = 11'd3; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 4) begin tick(); cyc++; end
    num_words = 11'd5; start = 1'b1;
    tick(); cyc++;
    start = 1'b0;
    while (!done && cyc < 200) begin tick(); cyc++; end
    check("busy_start_done_cycle", 32'(cyc), 32'd10);
    check("busy_start_dst0", mem[DST_WORD + 0], 32'd7);
    check("busy_start_dst1", mem[DST_WORD + 1], 32'd15);
    check("busy_start_dst2", mem[DST_WORD + 2], 32'd24);
    check("busy_start_dst3", mem[DST_WORD + 3], SENT);
    load(DST_WORD, SENT);
    num_words = 11'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done_clear", {30'd0, busy, done}, 32'd2);
    cyc = 1;
    while (!done && cyc < 200) begin tick(); cyc++; end
    check("restart_done_cycle", 32'(cyc), 32'd4);
    check("restart_dst0", mem[DST_WORD], 32'd7);

    // reset on the edge entering WR of word index 2
    for (int k = 0; k < 4; k++) load(k, 32'd1);
    for (int k = 0; k < 4; k++) load(DST_WORD + k, SENT);
    num_words = 11'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_outputs_zero", {bram_wrdata[15:0], bram_addr, bram_en}, 32'd0);
    check("rst_ctrl_zero", {24'd0, bram_we, 2'b00, busy, done}, 32'd0);
    tick(); tick(); tick();
    check("rst_dst0", mem[DST_WORD + 0], 32'd1);
    check("rst_dst1", mem[DST_WORD + 1], 32'd2);
    check("rst_dst2", mem[DST_WORD + 2], SENT);
    check("rst_dst3", mem[DST_WORD + 3], SENT);
    check("rst_idle_done", {31'd0, done}, 32'd0);
    run(2, cyc, b1);
    check("post_rst_done_cycle", 32'(cyc), 32'd7);
    check("post_rst_dst1", mem[DST_WORD + 1], 32'd2);
    check("post_rst_dst2", mem[DST_WORD + 2], SENT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
